// File: rtl/capture_ctrl.sv
// Capture controller: writes decimated samples into the circular channel RAMs,
// arms on full pre-trigger history, counts post-trigger samples, freezes trace_end.
// Optional macro AUTO_TRIG_EN adds a timeout that forces a trigger while armed.
module capture_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int DECIM_W = 4,
    parameter int TO_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [DECIM_W-1:0] decimator,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              triggered,
    input  logic              dump_done,
    output logic              we,
    output logic              cap_en,
    output logic [ADDR_W-1:0] cap_addr,
    output logic              armed,
    output logic [ADDR_W-1:0] trace_end,
    output logic              capture_done,
    output logic              auto_trigd
);

    localparam int DCNT_W = (1 << DECIM_W) - 1;
    localparam logic [ADDR_W:0]   DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DCNT_W-1:0] ONE_D   = {{(DCNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRT   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_r, next_state_s;

    logic [DCNT_W-1:0] dec_cnt_r, dec_mask_s;
    logic [ADDR_W:0]   smpl_cnt_r, post_cnt_r, pre_r, p_r, p_sel_s;
    logic [ADDR_W-1:0] cap_addr_r, trace_end_r;
    logic              we_r, cap_en_r, armed_r, capture_done_r, auto_trigd_r;
    logic              tick_s, trig_s, take_trig_s, fin_s, start_s, timeout_s;

    function automatic logic is_act(input state_t s);
        return (s == WRT) || (s == ARMED) || (s == POST);
    endfunction

    assign dec_mask_s = ~({DCNT_W{1'b1}} << decimator);
    assign tick_s     = (dec_cnt_r == dec_mask_s);
    assign p_sel_s    = (trig_pos == {ADDR_W{1'b0}}) ? ONE_C : {1'b0, trig_pos};
    assign trig_s     = triggered | timeout_s;
    assign start_s    = (state_r == IDLE) && (next_state_s == WRT);

`ifdef AUTO_TRIG_EN
    logic [TO_W-1:0] to_cnt_r;
    assign timeout_s = (state_r == ARMED) && (&to_cnt_r);

    // Timeout counter: runs only while staying in ARMED, zero on entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_r <= {TO_W{1'b0}};
        end else if ((state_r == ARMED) && (next_state_s == ARMED)) begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            to_cnt_r <= {TO_W{1'b0}};
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state logic; cap_en_r marks the write cycle, which is when counts advance
    always_comb begin
        next_state_s = state_r;
        take_trig_s  = 1'b0;
        fin_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (run && !capture_done_r) next_state_s = WRT;
                else                        next_state_s = IDLE;
            end
            WRT: begin
                if (!run)                                        next_state_s = IDLE;
                else if (cap_en_r && ((smpl_cnt_r + ONE_C) == pre_r)) next_state_s = ARMED;
                else                                             next_state_s = WRT;
            end
            ARMED: begin
                if (!run) begin
                    next_state_s = IDLE;
                end else if (trig_s) begin
                    take_trig_s = 1'b1;
                    if (cap_en_r && (p_r == ONE_C)) begin
                        fin_s        = 1'b1;
                        next_state_s = DONE;
                    end else begin
                        next_state_s = POST;
                    end
                end else begin
                    next_state_s = ARMED;
                end
            end
            POST: begin
                if (!run) begin
                    next_state_s = IDLE;
                end else if (cap_en_r && ((post_cnt_r + ONE_C) == p_r)) begin
                    fin_s        = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = POST;
                end
            end
            DONE: begin
                if (dump_done) next_state_s = IDLE;
                else           next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_state_s;
    end

    // Counters, sampled capture geometry and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_cnt_r      <= {DCNT_W{1'b0}};
            smpl_cnt_r     <= {(ADDR_W+1){1'b0}};
            post_cnt_r     <= {(ADDR_W+1){1'b0}};
            pre_r          <= {(ADDR_W+1){1'b0}};
            p_r            <= {(ADDR_W+1){1'b0}};
            cap_addr_r     <= {ADDR_W{1'b0}};
            trace_end_r    <= {ADDR_W{1'b0}};
            we_r           <= 1'b0;
            cap_en_r       <= 1'b0;
            armed_r        <= 1'b0;
            capture_done_r <= 1'b0;
            auto_trigd_r   <= 1'b0;
        end else begin
            we_r     <= is_act(next_state_s);
            armed_r  <= (next_state_s == ARMED);
            cap_en_r <= is_act(state_r) && is_act(next_state_s) && tick_s;

            if (is_act(state_r) && is_act(next_state_s)) begin
                dec_cnt_r <= tick_s ? {DCNT_W{1'b0}} : (dec_cnt_r + ONE_D);
            end else begin
                dec_cnt_r <= {DCNT_W{1'b0}};
            end

            if (cap_en_r) cap_addr_r <= cap_addr_r + ONE_A;

            if (start_s) begin
                smpl_cnt_r <= {(ADDR_W+1){1'b0}};
                p_r        <= p_sel_s;
                pre_r      <= DEPTH_V - p_sel_s;
            end else if ((state_r == WRT) && cap_en_r) begin
                smpl_cnt_r <= smpl_cnt_r + ONE_C;
            end

            if (take_trig_s) begin
                post_cnt_r <= cap_en_r ? ONE_C : {(ADDR_W+1){1'b0}};
            end else if ((state_r == POST) && cap_en_r) begin
                post_cnt_r <= post_cnt_r + ONE_C;
            end

            if (fin_s) begin
                trace_end_r    <= cap_addr_r;
                capture_done_r <= 1'b1;
            end else if ((state_r == DONE) && dump_done) begin
                capture_done_r <= 1'b0;
            end

`ifdef AUTO_TRIG_EN
            if (start_s)                        auto_trigd_r <= 1'b0;
            else if (take_trig_s && !triggered) auto_trigd_r <= 1'b1;
`endif
        end
    end

    assign we           = we_r;
    assign cap_en       = cap_en_r;
    assign cap_addr     = cap_addr_r;
    assign armed        = armed_r;
    assign trace_end    = trace_end_r;
    assign capture_done = capture_done_r;
    assign auto_trigd   = auto_trigd_r;

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Upstream stage of the RAM dump interface. It controls capture of decimated samples into the three 512-entry circular channel RAMs. It drives we/cap_en/cap_addr to the RAM interface, arms the trigger once enough pre-trigger history has been written, and counts post-trigger samples. On completion it freezes trace_end (the last written address) and raises capture_done for the dump side.

Parameters:
ADDR_W, 9, RAM address width; DEPTH = 2**ADDR_W
DECIM_W, 4, width of decimator exponent
TO_W, 20, auto-trigger timeout counter width (used only with AUTO_TRIG_EN)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
run  input  1  level; high = capture requested; low aborts capture
decimator  input  DECIM_W  sample every 2**decimator clocks
trig_pos  input  ADDR_W  number of post-trigger samples to keep
triggered  input  1  trigger event pulse/level from trigger logic
dump_done  input  1  pulse; dump finished, release buffer
we  output  1  capture mode (RAM interface selects cap_en/cap_addr)
cap_en  output  1  RAM write strobe, one clk per sample
cap_addr  output  ADDR_W  RAM write address
armed  output  1  pre-trigger history full; triggers now accepted
trace_end  output  ADDR_W  address of final written sample
capture_done  output  1  buffer frozen, ready to dump
auto_trigd  output  1  last capture ended via timeout (tied 0 without AUTO_TRIG_EN)

Behaviour:
- Reset: state IDLE; we=0, cap_en=0, cap_addr=0, armed=0, trace_end=0, capture_done=0, auto_trigd=0, all counters 0. Reset acts asynchronously at any point, including mid-capture.
- All outputs are registered.
- Decimation: dec_cnt runs only in WRT/ARMED/POST and is cleared on entry to WRT. Sample tick occurs when dec_cnt == 2**decimator-1, then dec_cnt wraps to 0. decimator=0 gives a tick every clk.
- cap_en = 1 for exactly one clk per tick while in WRT/ARMED/POST. cap_addr holds the address written during that cycle and increments the following clk, wrapping 2**ADDR_W-1 -> 0.
- Effective post count P = trig_pos, except that 0 is treated as 1. Pre count = DEPTH - P. Both are sampled on the IDLE->WRT transition.
- States:
  IDLE: we=0. When run=1 and capture_done=0, go to WRT and clear smpl_cnt. cap_addr is not reset, so it continues from its current value.
  WRT: we=1. smpl_cnt increments per tick. Go to ARMED on the clk after the tick at which smpl_cnt reaches pre count. armed=1 from that point.
  ARMED: we=1, armed=1. Writing continues. triggered=1 on any clk latches the trigger; go to POST with post_cnt=0. A tick in the same clk as triggered counts as post sample #1.
  POST: we=1, armed=0. post_cnt increments per tick. On the tick where post_cnt reaches P: trace_end <= cap_addr of that write, capture_done <= 1, go to DONE next clk with we=0.
  DONE: we=0, capture_done=1. Hold until dump_done; then clear capture_done and go to IDLE. run is ignored in DONE.
- triggered while in IDLE/WRT is ignored; no latching carries forward.
- run=0 in WRT/ARMED/POST: abort to IDLE next clk. we, cap_en, armed=0; capture_done stays 0; trace_end is unchanged.
- dump_done outside DONE is ignored.
- trig_pos/decimator changes mid-capture have no effect on P or pre count. decimator is sampled each tick compare.

Optional Feature:
AUTO_TRIG_EN
- Defined: a TO_W-bit timeout counter runs in ARMED and clears on entry. If it reaches all-ones without triggered, the block forces a trigger exactly as if triggered=1 that clk and sets auto_trigd=1. auto_trigd clears on the next IDLE->WRT transition.
- Undefined: no timeout counter; auto_trigd is tied 0; ARMED waits indefinitely.

Test Plan:
- decimator=0, trig_pos=256, run=1 from cap_addr=0; triggered pulse 10 clks after armed -> armed rises after 256 writes; 256 post writes follow; trace_end=(256+10+256-1)%512=9; capture_done=1; we=0.
- decimator=2 -> cap_en pulses exactly every 4 clks; cap_addr steps by 1 per pulse; wrap 511->0 verified.
- triggered pulsed during WRT, then no trigger -> stays ARMED, no capture_done; with AUTO_TRIG_EN, forced trigger after 2**20-1 clks and auto_trigd=1.
- trig_pos=0 -> treated as 1: exactly one post-trigger write; trace_end equals the address written in the trigger clk.
- run dropped in POST -> IDLE next clk; we=0; capture_done=0; trace_end unchanged. rst asserted mid-ARMED -> all outputs 0 immediately.
- In DONE, run toggled and triggered pulsed -> no change. dump_done pulse -> capture_done=0, IDLE; with run=1, next capture starts at cap_addr=trace_end+1.
